// File: rtl/pwm_capture_pkg.sv
// Shared state encoding for the PWM measurement/generation blocks.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_capture_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures high/low run lengths of pwm_in and reports them as (run length - 1),
// with a timeout strobe when the input sticks at one level.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] low_time,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    pwm_state_t       state, state_nxt;
    logic             s, s_d;
    logic             edge_ev, rise_ev, fall_ev;
    logic [WIDTH-1:0] cnt, h_hold;
    logic             cnt_max;

    logic             pub, pub_to, hold_en;
    logic [WIDTH-1:0] pub_lo, pub_hi;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (s)
    );

    assign edge_ev = s ^ s_d;
    assign rise_ev = edge_ev & s;
    assign fall_ev = edge_ev & ~s;
    assign cnt_max = &cnt;

    // cnt still holds the previous phase's length-1 during the edge cycle.
    always_comb begin
        state_nxt = state;
        pub       = 1'b0;
        pub_to    = 1'b0;
        pub_lo    = '0;
        pub_hi    = '0;
        hold_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_ev) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall_ev) begin
                    hold_en   = 1'b1;
                    state_nxt = ST_LOW;
                end else if (!edge_ev && cnt_max) begin
                    pub       = 1'b1;
                    pub_to    = 1'b1;
                    pub_hi    = '1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise_ev) begin
                    pub       = 1'b1;
                    pub_lo    = cnt;
                    pub_hi    = h_hold;
                    state_nxt = ST_HIGH;
                end else if (!edge_ev && cnt_max) begin
                    pub       = 1'b1;
                    pub_to    = 1'b1;
                    pub_lo    = '1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_d       <= 1'b0;
            cnt       <= '0;
            h_hold    <= '0;
            low_time  <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_d     <= s;
            valid   <= pub;
            timeout <= pub_to;
            if (edge_ev)       cnt <= '0;
            else if (!cnt_max) cnt <= cnt + WIDTH'(1);
            if (hold_en) h_hold <= cnt;
            if (pub) begin
                low_time  <= pub_lo;
                high_time <= pub_hi;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: drivers queue expected {low,high,timeout}; monitors pop on valid.
module tb_pwm_capture;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        pwm_a, pwm_b;
    logic [3:0]  lo_a, hi_a;
    logic [15:0] lo_b, hi_b;
    logic        valid_a, valid_b, to_a, to_b;

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    pwm_capture #(.WIDTH(4), .SYNC_STAGES(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_a_n),
        .pwm_in    (pwm_a),
        .low_time  (lo_a),
        .high_time (hi_a),
        .valid     (valid_a),
        .timeout   (to_a)
    );

    pwm_capture #(.WIDTH(16), .SYNC_STAGES(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_b_n),
        .pwm_in    (pwm_b),
        .low_time  (lo_b),
        .high_time (hi_b),
        .valid     (valid_b),
        .timeout   (to_b)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int lo, input int hi, input bit to);
        exp_t e;
        e.lo = 16'(lo);
        e.hi = 16'(hi);
        e.to = to;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_a_n && (valid_a || to_a)) begin
            if (!valid_a) begin
                check("a_timeout_without_valid", {39'd0, to_a}, 40'd0);
            end else if (q_a.size() == 0) begin
                check("a_unexpected_valid", {16'(lo_a), 16'(hi_a), 8'(to_a)}, 40'd0);
            end else begin
                e = q_a.pop_front();
                check("a_publish", {16'(lo_a), 16'(hi_a), 8'(to_a)}, {e.lo, e.hi, 8'(e.to)});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_b_n && (valid_b || to_b)) begin
            if (!valid_b) begin
                check("b_timeout_without_valid", {39'd0, to_b}, 40'd0);
            end else if (q_b.size() == 0) begin
                check("b_unexpected_valid", {lo_b, hi_b, 8'(to_b)}, 40'd0);
            end else begin
                e = q_b.pop_front();
                check("b_publish", {lo_b, hi_b, 8'(to_b)}, {e.lo, e.hi, 8'(e.to)});
            end
        end
    end

    // Level applied just after a falling clock edge and held for n cycles.
    task automatic hold_a(input logic lvl, input int n, input bit meas);
        int lat = 0;
        pwm_a = lvl;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (meas && lat == 0 && valid_a) lat = i;
            @(negedge clk);
        end
        if (meas) check("a_latency", 40'(lat), 40'd3);
    endtask

    task automatic hold_b(input logic lvl, input int n, input bit meas);
        int lat = 0;
        pwm_b = lvl;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (meas && lat == 0 && valid_b) lat = i;
            @(negedge clk);
        end
        if (meas) check("b_latency", 40'(lat), 40'd4);
    endtask

    task automatic run_a;
        hold_a(1'b0, 4, 1'b0);
        hold_a(1'b1, 1, 1'b0);
        hold_a(1'b0, 2, 1'b0);
        q_a.push_back(mk(1, 0, 1'b0));      // glitch: high 1, low 2
        hold_a(1'b1, 3, 1'b1);
        hold_a(1'b0, 5, 1'b0);
        q_a.push_back(mk(4, 2, 1'b0));
        hold_a(1'b1, 16, 1'b0);             // falls on the saturation cycle
        hold_a(1'b0, 3, 1'b0);
        q_a.push_back(mk(2, 15, 1'b0));
        hold_a(1'b1, 2, 1'b0);
        q_a.push_back(mk(15, 0, 1'b1));     // stuck low
        hold_a(1'b0, 40, 1'b0);
        hold_a(1'b1, 4, 1'b0);
        hold_a(1'b0, 3, 1'b0);
        q_a.push_back(mk(2, 3, 1'b0));
        q_a.push_back(mk(0, 15, 1'b1));     // stuck high
        hold_a(1'b1, 20, 1'b0);
        hold_a(1'b0, 5, 1'b0);
        hold_a(1'b1, 2, 1'b0);
        hold_a(1'b0, 2, 1'b0);
        q_a.push_back(mk(1, 1, 1'b0));
        hold_a(1'b1, 5, 1'b0);
        hold_a(1'b0, 2, 1'b0);
    endtask

    task automatic run_b;
        hold_b(1'b0, 4, 1'b0);
        hold_b(1'b1, 6, 1'b0);
        for (int p = 0; p < 4; p++) begin
            hold_b(1'b0, 4, 1'b0);
            q_b.push_back(mk(3, 5, 1'b0));
            hold_b(1'b1, 6, p == 0);
        end
        hold_b(1'b0, 4, 1'b0);
        q_b.push_back(mk(3, 5, 1'b0));
        hold_b(1'b1, 5, 1'b0);
        rst_b_n = 1'b0;                     // mid-HIGH reset, pwm stays high
        #1;
        check("b_rst_low_time",  40'(lo_b), 40'd0);
        check("b_rst_high_time", 40'(hi_b), 40'd0);
        check("b_rst_valid",     40'(valid_b), 40'd0);
        check("b_rst_timeout",   40'(to_b), 40'd0);
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
        hold_b(1'b1, 7, 1'b0);
        hold_b(1'b0, 4, 1'b0);
        q_b.push_back(mk(3, 6, 1'b0));
        hold_b(1'b1, 6, 1'b0);
        hold_b(1'b0, 4, 1'b0);
        q_b.push_back(mk(3, 5, 1'b0));
        hold_b(1'b1, 6, 1'b0);
        hold_b(1'b0, 4, 1'b0);
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        pwm_a   = 1'b0;
        pwm_b   = 1'b0;
        #1;
        check("a_reset_out", {16'(lo_a), 16'(hi_a), 6'd0, valid_a, to_a}, 40'd0);
        check("b_reset_out", {lo_b, hi_b, 6'd0, valid_b, to_b}, 40'd0);
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        fork
            run_a();
            run_b();
        join
        repeat (10) @(negedge clk);
        check("a_queue_drained", 40'(q_a.size()), 40'd0);
        check("b_queue_drained", 40'(q_b.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
